// File: rtl/scan_pkg.sv
// Shared definitions for the scan access port slice.
//   scan_state_t    : FSM state encoding used by the scan engine
//   CHAIN_W_DEFAULT : default scan chain length (AES state width)
//   LOCK_CLEAR      : value loaded into the chain when scan permission is revoked
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT_IN  = 3'd1,
    APPLY     = 3'd2,
    CAPTURE   = 3'd3,
    SHIFT_OUT = 3'd4
  } scan_state_t;

  localparam int CHAIN_W_DEFAULT = 128;

  localparam logic [CHAIN_W_DEFAULT-1:0] LOCK_CLEAR = {CHAIN_W_DEFAULT{1'b0}};

endpackage

// File: rtl/scan_access_port_if.sv
// Serial scan handshake bundle between the tester and the scan access port.
//   si / si_valid / si_ready : serial data into the port (tester -> port)
//   so / so_valid / so_ready : serial data out of the port (port -> tester)
// master = tester side, slave = scan access port side.
interface scan_access_port_if;

  logic si;
  logic si_valid;
  logic si_ready;
  logic so;
  logic so_valid;
  logic so_ready;

  modport master (
    output si, si_valid, so_ready,
    input  si_ready, so, so_valid
  );

  modport slave (
    input  si, si_valid, so_ready,
    output si_ready, so, so_valid
  );

endinterface

// File: rtl/scan_shift_reg.sv
// CHAIN_W-bit scan chain register.
//   clk, reset_n : clock, synchronous active-low reset
//   clear        : synchronous wipe to LOCK_CLEAR (highest functional priority)
//   load, load_d : parallel load
//   shift, shift_bit : shift left by one, shift_bit enters at the LSB
//   q            : register contents
//   serial_out   : MSB, the next bit to leave the chain
module scan_shift_reg
  import scan_pkg::*;
#(
  parameter int CHAIN_W = CHAIN_W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               load,
  input  logic [CHAIN_W-1:0] load_d,
  input  logic               shift,
  input  logic               shift_bit,
  output logic [CHAIN_W-1:0] q,
  output logic               serial_out
);

  logic [CHAIN_W-1:0] q_r;

  // Chain storage: clear beats load beats shift.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_r <= CHAIN_W'(LOCK_CLEAR);
    end else if (clear) begin
      q_r <= CHAIN_W'(LOCK_CLEAR);
    end else if (load) begin
      q_r <= load_d;
    end else if (shift) begin
      q_r <= {q_r[CHAIN_W-2:0], shift_bit};
    end else begin
      q_r <= q_r;
    end
  end

  assign q          = q_r;
  assign serial_out = q_r[CHAIN_W-1];

endmodule

// File: rtl/scan_access_port.sv
// Tester-side scan engine: shifts a test vector into the AES state register,
// applies it, captures the register and shifts the capture back out. Any loss
// of scan permission kills the operation and wipes the chain immediately.
//   clk, reset_n          : clock, synchronous active-low reset
//   scan_mode, enable_scan_in, enable_scan_out : permissions from the test controller
//   start                 : single-cycle request to begin an operation
//   sif (slave)           : serial si/so handshake to the tester
//   chain_q, chain_load   : vector and load strobe towards the AES state register
//   capture_d             : AES state register contents to capture
//   busy                  : operation in progress
//   done                  : one-cycle pulse after the last bit left normally
//   abort                 : one-cycle pulse after an operation was killed by lock
module scan_access_port
  import scan_pkg::*;
#(
  parameter int CHAIN_W = CHAIN_W_DEFAULT,
  parameter int CNT_W   = 7
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                scan_mode,
  input  logic                enable_scan_in,
  input  logic                enable_scan_out,
  input  logic                start,
  scan_access_port_if.slave   sif,
  output logic [CHAIN_W-1:0]  chain_q,
  output logic                chain_load,
  input  logic [CHAIN_W-1:0]  capture_d,
  output logic                busy,
  output logic                done,
  output logic                abort
);

  scan_state_t        state_r;
  scan_state_t        state_nxt_s;
  logic [CNT_W-1:0]   cnt_r;
  logic               done_r;
  logic               abort_r;

  logic               lock_s;
  logic               last_cnt_s;
  logic               sr_clear_s;
  logic               sr_load_s;
  logic               sr_shift_s;
  logic               sr_bit_s;
  logic [CHAIN_W-1:0] sr_q_s;
  logic               sr_msb_s;
  logic               cnt_clear_s;
  logic               cnt_inc_s;
  logic               done_set_s;
  logic               abort_set_s;
  logic               si_ready_s;
  logic               so_valid_s;
  logic               chain_load_s;
  logic [CHAIN_W-1:0] chain_q_s;

  assign lock_s     = ~scan_mode | ~enable_scan_in | ~enable_scan_out;
  assign last_cnt_s = (cnt_r == CNT_W'(CHAIN_W - 1));

  scan_shift_reg #(
    .CHAIN_W (CHAIN_W)
  ) u_shift_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (sr_clear_s),
    .load       (sr_load_s),
    .load_d     (capture_d),
    .shift      (sr_shift_s),
    .shift_bit  (sr_bit_s),
    .q          (sr_q_s),
    .serial_out (sr_msb_s)
  );

  // Next-state and datapath controls; lock overrides every other transition.
  always_comb begin
    state_nxt_s  = state_r;
    sr_clear_s   = 1'b0;
    sr_load_s    = 1'b0;
    sr_shift_s   = 1'b0;
    sr_bit_s     = 1'b0;
    cnt_clear_s  = 1'b0;
    cnt_inc_s    = 1'b0;
    done_set_s   = 1'b0;
    abort_set_s  = 1'b0;
    si_ready_s   = 1'b0;
    so_valid_s   = 1'b0;
    chain_load_s = 1'b0;
    chain_q_s    = {CHAIN_W{1'b0}};

    if ((state_r != IDLE) && lock_s) begin
      state_nxt_s = IDLE;
      sr_clear_s  = 1'b1;
      cnt_clear_s = 1'b1;
      abort_set_s = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (start && !lock_s) begin
            state_nxt_s = SHIFT_IN;
            cnt_clear_s = 1'b1;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        SHIFT_IN: begin
          si_ready_s = 1'b1;
          sr_bit_s   = sif.si;
          if (sif.si_valid) begin
            sr_shift_s = 1'b1;
            if (last_cnt_s) begin
              state_nxt_s = APPLY;
              cnt_clear_s = 1'b1;
            end else begin
              cnt_inc_s = 1'b1;
            end
          end else begin
            state_nxt_s = SHIFT_IN;
          end
        end
        APPLY: begin
          chain_load_s = 1'b1;
          chain_q_s    = sr_q_s;
          state_nxt_s  = CAPTURE;
        end
        CAPTURE: begin
          chain_q_s   = sr_q_s;
          sr_load_s   = 1'b1;
          state_nxt_s = SHIFT_OUT;
        end
        SHIFT_OUT: begin
          so_valid_s = 1'b1;
          if (sif.so_ready) begin
            // Zeros fill from the LSB, so the chain is empty after the last bit.
            sr_shift_s = 1'b1;
            if (last_cnt_s) begin
              state_nxt_s = IDLE;
              cnt_clear_s = 1'b1;
              done_set_s  = 1'b1;
            end else begin
              cnt_inc_s = 1'b1;
            end
          end else begin
            state_nxt_s = SHIFT_OUT;
          end
        end
        default: begin
          state_nxt_s = IDLE;
          sr_clear_s  = 1'b1;
          cnt_clear_s = 1'b1;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Bit counter shared by shift-in and shift-out.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clear_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Completion / abort pulses, one cycle after the deciding event.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      done_r  <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      done_r  <= done_set_s;
      abort_r <= abort_set_s;
    end
  end

  assign sif.si_ready = si_ready_s;
  assign sif.so_valid = so_valid_s;
  assign sif.so       = so_valid_s & sr_msb_s;
  assign chain_q      = chain_q_s;
  assign chain_load   = chain_load_s;
  assign busy         = (state_r != IDLE);
  assign done         = done_r;
  assign abort        = abort_r;

endmodule

// File: doc/scan_access_port.md
Name: scan_access_port

Overview:
- Tester-side scan engine; consumes the scan_mode / enable_scan_in / enable_scan_out permissions produced by the secure-scan test controller.
- Serially loads a CHAIN_W-bit test vector into the AES state register, applies it, and captures the state register contents.
- Shifts the captured contents back out to the tester.
- Aborts and wipes its chain the moment scan permission is revoked, so no key-dependent data leaves after secure mode locks.

Parameters:
CHAIN_W, 128, scan chain length in bits (AES state width)
CNT_W, 7, bit-counter width; must satisfy 2**CNT_W >= CHAIN_W

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
scan_mode  input  1  scan permitted (from test controller)
enable_scan_in  input  1  shift-in permitted
enable_scan_out  input  1  shift-out permitted
start  input  1  single-cycle request to begin a scan operation
si  input  1  serial scan data in
si_valid  input  1  si holds a valid bit
si_ready  output  1  port accepts si this cycle
so  output  1  serial scan data out
so_valid  output  1  so holds a valid bit
so_ready  input  1  tester accepts so this cycle
chain_q  output  CHAIN_W  shifted-in vector driven to the AES state register
chain_load  output  1  one-cycle strobe: AES register loads chain_q
capture_d  input  CHAIN_W  AES state register contents for capture
busy  output  1  operation in progress (state != IDLE)
done  output  1  one-cycle pulse: shift-out completed normally
abort  output  1  one-cycle pulse: operation killed by lock

Behaviour:
- Reset (reset_n=0 at posedge clk): state=IDLE, shift register=0, counter=0. All outputs 0; chain_q=0.
- lock = ~scan_mode | ~enable_scan_in | ~enable_scan_out, evaluated combinationally every cycle.
- FSM states: IDLE, SHIFT_IN, APPLY, CAPTURE, SHIFT_OUT.
- IDLE:
  - start=1 and lock=0 -> SHIFT_IN, counter=0.
  - start while locked is ignored; no abort pulse.
- SHIFT_IN:
  - si_ready=1.
  - On si_valid & si_ready, shift register <= {sr[CHAIN_W-2:0], si}. The first bit received ends at MSB.
  - Counter increments on each accepted bit. When the accept occurs with counter==CHAIN_W-1, go to APPLY and clear the counter.
  - Stalls indefinitely while si_valid=0.
- APPLY: chain_load=1 for exactly this one cycle -> CAPTURE.
- CAPTURE: shift register <= capture_d (sampled the cycle after chain_load) -> SHIFT_OUT.
- SHIFT_OUT:
  - so = sr[CHAIN_W-1] and so_valid=1.
  - On so_ready, shift register <= {sr[CHAIN_W-2:0], 1'b0} and the counter increments.
  - The accept with counter==CHAIN_W-1 -> IDLE with done=1 in the following cycle. The shift register is then all zeros.
  - so/so_valid are held stable while so_ready=0.
- chain_q mirrors the shift register only while in APPLY and CAPTURE; it is 0 in every other state, so no partial vectors are exposed.
- so is forced to 0 whenever so_valid=0.
- Lock in any non-IDLE state:
  - Next state is IDLE, shift register and counter are cleared, abort=1 for one cycle.
  - The bit offered on si in that cycle is not accepted: si_ready=0 combinationally while lock=1.
  - so_valid=0 in the lock cycle.
  - Lock takes priority over every other transition, including the final shift bit.
- start asserted while busy is ignored.
- Reset mid-operation behaves identically to power-on reset; no abort pulse is produced.
- done and abort are never asserted in the same cycle.

Decomposition:
- Shared package scan_pkg holds:
  - The state encoding typedef (IDLE, SHIFT_IN, APPLY, CAPTURE, SHIFT_OUT).
  - CHAIN_W_DEFAULT=128.
  - The LOCK_CLEAR value (all zeros).
- One natural sub-module: scan_shift_reg. It is a CHAIN_W-bit register with shift-in, parallel load, and synchronous clear, plus serial out.
- The FSM and counter stay in scan_access_port.

Test Plan:
- CHAIN_W=8, lock=0: start, then shift si=1,0,1,1,0,0,1,0 with si_valid held 1.
  - chain_load pulses with chain_q=8'hB2.
  - Then capture_d=8'h5C is shifted out MSB-first as 0,1,0,1,1,1,0,0.
  - done pulses once; busy=0 afterwards.
- Backpressure:
  - si_valid toggles 1/0 during SHIFT_IN -> chain_q is still exactly the accepted bits.
  - so_ready low for 3 cycles mid-unload -> so/so_valid are held constant and no bit is lost.
- Lock mid-shift: enable_scan_in drops after 4 of 8 bits.
  - abort pulses next cycle and state returns to IDLE.
  - chain_load never asserts; chain_q=0; si_ready=0.
  - A later start with lock still set is ignored.
- Lock during SHIFT_OUT: scan_mode drops after 3 bits out.
  - so_valid=0 in the same cycle and abort pulses; no further so bits appear.
  - The internal register is cleared; a subsequent legal start unloads the new capture, not residue.
- reset_n=0 for one cycle during CAPTURE:
  - All outputs are 0 next cycle with no abort.
  - A start after release runs a full operation correctly.
- Lock coincident with the final shift-in accept (counter==7):
  - Lock wins, abort=1, and chain_load is never asserted.
